// File: rtl/ddr_cmd_timing_monitor.sv
// Passive DDR command-bus monitor: tracks per-bank open state and tRCD/tRP/tRAS/tRFC windows,
// reporting each violation as a registered one-cycle event with sticky flags and a saturating count.
module ddr_cmd_timing_monitor #(
   parameter int unsigned BANK_WIDTH    = 3,
   parameter int unsigned ROW_WIDTH     = 14,
   parameter int unsigned T_RCD         = 4,
   parameter int unsigned T_RP          = 4,
   parameter int unsigned T_RAS         = 12,
   parameter int unsigned T_RFC         = 52,
   parameter int unsigned TMR_WIDTH     = 8,
   parameter int unsigned ERR_CNT_WIDTH = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         mon_en,
   input  logic                         clr,
   input  logic                         ddr_cke,
   input  logic                         ddr_cs_n,
   input  logic                         ddr_ras_n,
   input  logic                         ddr_cas_n,
   input  logic                         ddr_we_n,
   input  logic [BANK_WIDTH-1:0]        ddr_ba,
   input  logic [ROW_WIDTH-1:0]         ddr_a,
   output logic                         viol_valid,
   output logic [2:0]                   viol_code,
   output logic [BANK_WIDTH-1:0]        viol_bank,
   output logic [6:0]                   viol_flags,
   output logic [ERR_CNT_WIDTH-1:0]     err_count,
   output logic [(2**BANK_WIDTH)-1:0]   bank_open
);

   localparam int unsigned NUM_BANKS = 2**BANK_WIDTH;
   localparam logic [TMR_WIDTH-1:0] RCD_LD = TMR_WIDTH'(T_RCD - 1);
   localparam logic [TMR_WIDTH-1:0] RP_LD  = TMR_WIDTH'(T_RP - 1);
   localparam logic [TMR_WIDTH-1:0] RAS_LD = TMR_WIDTH'(T_RAS - 1);
   localparam logic [TMR_WIDTH-1:0] RFC_LD = TMR_WIDTH'(T_RFC - 1);

   logic [TMR_WIDTH-1:0]     rcd_q [NUM_BANKS];
   logic [TMR_WIDTH-1:0]     rcd_d [NUM_BANKS];
   logic [TMR_WIDTH-1:0]     rp_q  [NUM_BANKS];
   logic [TMR_WIDTH-1:0]     rp_d  [NUM_BANKS];
   logic [TMR_WIDTH-1:0]     ras_q [NUM_BANKS];
   logic [TMR_WIDTH-1:0]     ras_d [NUM_BANKS];
   logic [TMR_WIDTH-1:0]     rfc_q, rfc_d;
   logic [NUM_BANKS-1:0]     open_q, open_d;
   logic                     viol_valid_q, viol_valid_d;
   logic [2:0]               viol_code_q, viol_code_d;
   logic [BANK_WIDTH-1:0]    viol_bank_q, viol_bank_d;
   logic [6:0]               viol_flags_q, viol_flags_d;
   logic [ERR_CNT_WIDTH-1:0] err_count_q, err_count_d;

   logic                     cmd_sel, is_act, is_rw, is_pre, is_ref, cmd_dec, pre_all;
   logic [2:0]               rcw;
   logic [6:0]               hit;
   logic                     pre_found;
   logic [BANK_WIDTH-1:0]    pre_bank;
   logic [2:0]               code_c;
   logic                     unused_addr;

   // Only a[10] matters; the rest of the address bus is observed but ignored.
   assign unused_addr = ^ddr_a;

   assign cmd_sel = ddr_cke && !ddr_cs_n;
   assign rcw     = {ddr_ras_n, ddr_cas_n, ddr_we_n};
   assign is_act  = cmd_sel && (rcw == 3'b011);
   assign is_rw   = cmd_sel && ((rcw == 3'b101) || (rcw == 3'b100));
   assign is_pre  = cmd_sel && (rcw == 3'b010);
   assign is_ref  = cmd_sel && (rcw == 3'b001);
   assign cmd_dec = is_act || is_rw || is_pre || is_ref;
   assign pre_all = is_pre && ddr_a[10];

   function automatic logic [TMR_WIDTH-1:0] tmr_dec(input logic [TMR_WIDTH-1:0] t);
      return (t == '0) ? '0 : t - TMR_WIDTH'(1);
   endfunction

   // Next-state: timers, bank state, violation detection and reporting
   always_comb begin
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
         rcd_d[b] = tmr_dec(rcd_q[b]);
         rp_d[b]  = tmr_dec(rp_q[b]);
         ras_d[b] = tmr_dec(ras_q[b]);
      end
      rfc_d        = tmr_dec(rfc_q);
      open_d       = open_q;
      hit          = '0;
      pre_found    = 1'b0;
      pre_bank     = '0;
      code_c       = '0;
      viol_valid_d = 1'b0;
      viol_code_d  = '0;
      viol_bank_d  = '0;
      viol_flags_d = viol_flags_q;
      err_count_d  = err_count_q;

      // Precharge closes each targeted open bank; the lowest early one is the reported bank
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
         if (is_pre && (pre_all || (ddr_ba == BANK_WIDTH'(b))) && open_q[b]) begin
            rp_d[b]   = RP_LD;
            open_d[b] = 1'b0;
            if ((ras_q[b] != '0) && !pre_found) begin
               pre_found = 1'b1;
               pre_bank  = BANK_WIDTH'(b);
            end
         end
      end
      if (is_act) begin
         rcd_d[ddr_ba]  = RCD_LD;
         ras_d[ddr_ba]  = RAS_LD;
         open_d[ddr_ba] = 1'b1;
      end
      if (is_ref) begin
         rfc_d = RFC_LD;
      end

      hit[0] = is_rw && (rcd_q[ddr_ba] != '0);
      hit[1] = is_act && (rp_q[ddr_ba] != '0);
      hit[2] = pre_found;
      hit[3] = cmd_dec && (rfc_q != '0);
      hit[4] = is_act && open_q[ddr_ba];
      hit[5] = is_rw && !open_q[ddr_ba];
      hit[6] = is_ref && (|open_q);

      // Lowest code wins: scan downwards so the last assignment is the lowest hit
      for (int c = 6; c >= 0; c--) begin
         if (hit[c]) begin
            code_c = 3'(c + 1);
         end
      end

      if (clr) begin
         viol_flags_d = '0;
         err_count_d  = '0;
      end
      if (mon_en && (hit != '0)) begin
         viol_valid_d = 1'b1;
         viol_code_d  = code_c;
         case (code_c)
            3'd3:       viol_bank_d = pre_bank;
            3'd4, 3'd7: viol_bank_d = '0;
            default:    viol_bank_d = ddr_ba;
         endcase
         viol_flags_d = viol_flags_d | hit;
         if (err_count_d != '1) begin
            err_count_d = err_count_d + ERR_CNT_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            rcd_q[b] <= '0;
            rp_q[b]  <= '0;
            ras_q[b] <= '0;
         end
         rfc_q        <= '0;
         open_q       <= '0;
         viol_valid_q <= 1'b0;
         viol_code_q  <= '0;
         viol_bank_q  <= '0;
         viol_flags_q <= '0;
         err_count_q  <= '0;
      end else begin
         for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            rcd_q[b] <= rcd_d[b];
            rp_q[b]  <= rp_d[b];
            ras_q[b] <= ras_d[b];
         end
         rfc_q        <= rfc_d;
         open_q       <= open_d;
         viol_valid_q <= viol_valid_d;
         viol_code_q  <= viol_code_d;
         viol_bank_q  <= viol_bank_d;
         viol_flags_q <= viol_flags_d;
         err_count_q  <= err_count_d;
      end
   end

   assign viol_valid = viol_valid_q;
   assign viol_code  = viol_code_q;
   assign viol_bank  = viol_bank_q;
   assign viol_flags = viol_flags_q;
   assign err_count  = err_count_q;
   assign bank_open  = open_q;

endmodule

// File: tb/tb_ddr_cmd_timing_monitor.sv
// Scoreboard bench for ddr_cmd_timing_monitor: a cycle-stamp reference model predicts every
// registered output; directed scenarios plus randomized command traffic.
module tb_ddr_cmd_timing_monitor;

   localparam int BW    = 3;
   localparam int NB    = 8;
   localparam int RW    = 14;
   localparam int CW    = 4;
   localparam int TRCD  = 4;
   localparam int TRP   = 4;
   localparam int TRAS  = 12;
   localparam int TRFC  = 52;
   localparam int CMAX  = 15;

   localparam bit [2:0] C_NOP = 3'b111;
   localparam bit [2:0] C_ACT = 3'b011;
   localparam bit [2:0] C_RD  = 3'b101;
   localparam bit [2:0] C_WR  = 3'b100;
   localparam bit [2:0] C_PRE = 3'b010;
   localparam bit [2:0] C_REF = 3'b001;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          mon_en = 1'b1;
   logic          clr = 1'b0;
   logic          ddr_cke = 1'b1;
   logic          ddr_cs_n = 1'b1;
   logic          ddr_ras_n = 1'b1;
   logic          ddr_cas_n = 1'b1;
   logic          ddr_we_n = 1'b1;
   logic [BW-1:0] ddr_ba = '0;
   logic [RW-1:0] ddr_a = '0;
   logic          viol_valid;
   logic [2:0]    viol_code;
   logic [BW-1:0] viol_bank;
   logic [6:0]    viol_flags;
   logic [CW-1:0] err_count;
   logic [NB-1:0] bank_open;

   ddr_cmd_timing_monitor #(
      .BANK_WIDTH(BW), .ROW_WIDTH(RW), .T_RCD(TRCD), .T_RP(TRP), .T_RAS(TRAS),
      .T_RFC(TRFC), .TMR_WIDTH(8), .ERR_CNT_WIDTH(CW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .mon_en(mon_en), .clr(clr), .ddr_cke(ddr_cke),
      .ddr_cs_n(ddr_cs_n), .ddr_ras_n(ddr_ras_n), .ddr_cas_n(ddr_cas_n), .ddr_we_n(ddr_we_n),
      .ddr_ba(ddr_ba), .ddr_a(ddr_a), .viol_valid(viol_valid), .viol_code(viol_code),
      .viol_bank(viol_bank), .viol_flags(viol_flags), .err_count(err_count), .bank_open(bank_open)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit       v;
      bit [2:0] code;
      bit [2:0] bank;
      bit [6:0] flags;
      int       cnt;
      bit [7:0] open;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: remembers when each event last happened and derives windows from elapsed cycles
   longint   mcyc;
   longint   act_c[NB];
   longint   pre_c[NB];
   longint   ref_c;
   bit [7:0] open_m;
   bit [6:0] flags_m;
   int       cnt_m;

   function automatic void model_reset();
      for (int b = 0; b < NB; b++) begin
         act_c[b] = -1000;
         pre_c[b] = -1000;
      end
      ref_c   = -1000;
      open_m  = '0;
      flags_m = '0;
      cnt_m   = 0;
   endfunction

   task automatic chk(input string nm, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, got, want, $time);
      end
   endtask

   task automatic step(input bit [2:0] rcw, input int ba, input bit a10, input bit cke_i,
                       input bit cs_i, input bit en_i, input bit clr_i);
      bit [6:0] h;
      bit       dec, act, rw, pre, rf;
      int       pb;
      exp_t     e;
      @(negedge clk);
      ddr_cke  = cke_i;
      ddr_cs_n = cs_i;
      {ddr_ras_n, ddr_cas_n, ddr_we_n} = rcw;
      ddr_ba   = BW'(ba);
      ddr_a    = RW'($urandom);
      ddr_a[10] = a10;
      mon_en   = en_i;
      clr      = clr_i;

      dec = cke_i && !cs_i && (rcw inside {C_ACT, C_RD, C_WR, C_PRE, C_REF});
      act = dec && (rcw == C_ACT);
      rw  = dec && (rcw == C_RD || rcw == C_WR);
      pre = dec && (rcw == C_PRE);
      rf  = dec && (rcw == C_REF);
      h   = '0;
      pb  = -1;
      if (rw && (mcyc - act_c[ba] < TRCD)) h[0] = 1'b1;
      if (act && (mcyc - pre_c[ba] < TRP)) h[1] = 1'b1;
      if (pre) begin
         for (int b = 0; b < NB; b++) begin
            if ((a10 || b == ba) && open_m[b] && (mcyc - act_c[b] < TRAS) && pb < 0) pb = b;
         end
      end
      h[2] = (pb >= 0);
      if (dec && (mcyc - ref_c < TRFC)) h[3] = 1'b1;
      if (act && open_m[ba]) h[4] = 1'b1;
      if (rw && !open_m[ba]) h[5] = 1'b1;
      if (rf && (open_m != 0)) h[6] = 1'b1;

      e.v = 1'b0; e.code = '0; e.bank = '0;
      if (clr_i) begin
         flags_m = '0;
         cnt_m   = 0;
      end
      if (en_i && h != 0) begin
         e.v = 1'b1;
         for (int c = 0; c < 7; c++) begin
            if (h[c] && e.code == 0) e.code = 3'(c + 1);
         end
         if (e.code == 3)                     e.bank = 3'(pb);
         else if (e.code == 4 || e.code == 7) e.bank = 3'd0;
         else                                 e.bank = 3'(ba);
         flags_m = flags_m | h;
         if (cnt_m < CMAX) cnt_m++;
      end

      if (pre) begin
         for (int b = 0; b < NB; b++) begin
            if ((a10 || b == ba) && open_m[b]) begin
               pre_c[b]  = mcyc;
               open_m[b] = 1'b0;
            end
         end
      end
      if (act) begin
         act_c[ba]  = mcyc;
         open_m[ba] = 1'b1;
      end
      if (rf) ref_c = mcyc;

      e.flags = flags_m;
      e.cnt   = cnt_m;
      e.open  = open_m;
      exp_q.push_back(e);
      mcyc++;
      @(posedge clk);
   endtask

   task automatic cmd(input bit [2:0] rcw, input int ba, input bit a10);
      step(rcw, ba, a10, 1'b1, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic nops(input int n);
      for (int i = 0; i < n; i++) cmd(C_NOP, 0, 1'b0);
   endtask

   task automatic idle_inputs();
      ddr_cke = 1'b1; ddr_cs_n = 1'b1;
      {ddr_ras_n, ddr_cas_n, ddr_we_n} = C_NOP;
      mon_en = 1'b1; clr = 1'b0;
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_valid"}, int'(viol_valid), 0);
      chk({nm, "_state"}, int'({viol_code, viol_bank, viol_flags, err_count, bank_open}), 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      idle_inputs();
      #1 chk_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   // Monitor: one prediction per issued command, compared one step after it
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (rst_n && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (viol_valid !== e.v || viol_code !== e.code || viol_bank !== e.bank ||
             viol_flags !== e.flags || int'(err_count) != e.cnt || bank_open !== e.open) begin
            errors++;
            $display("FAIL sb t=%0t got v=%0d code=%0d bank=%0d flags=%b cnt=%0d open=%b want v=%0d code=%0d bank=%0d flags=%b cnt=%0d open=%b",
                     $time, viol_valid, viol_code, viol_bank, viol_flags, err_count, bank_open,
                     e.v, e.code, e.bank, e.flags, e.cnt, e.open);
         end
      end
   end

   initial begin
      bit [2:0] rcw;
      int       r;
      mcyc = 0;
      model_reset();
      #1 chk_zero("por");
      do_reset();

      // tRCD violation
      cmd(C_ACT, 2, 0); nops(2); cmd(C_RD, 2, 0);
      #2;
      chk("t1_valid", int'(viol_valid), 1);
      chk("t1_code",  int'(viol_code), 1);
      chk("t1_bank",  int'(viol_bank), 2);
      chk("t1_flags", int'(viol_flags), 1);
      chk("t1_cnt",   int'(err_count), 1);

      // Legal ACT/PRE/ACT sequence
      do_reset();
      cmd(C_ACT, 1, 0); nops(11); cmd(C_PRE, 1, 0); nops(3); cmd(C_ACT, 1, 0);
      #2;
      chk("t2_valid", int'(viol_valid), 0);
      chk("t2_flags", int'(viol_flags), 0);
      chk("t2_open1", int'(bank_open[1]), 1);

      // Early precharge-all reports lowest bank
      do_reset();
      cmd(C_ACT, 0, 0); nops(1); cmd(C_ACT, 5, 0); nops(5); cmd(C_PRE, 3, 1);
      #2;
      chk("t3_code",  int'(viol_code), 3);
      chk("t3_bank",  int'(viol_bank), 0);
      chk("t3_open",  int'(bank_open), 0);
      chk("t3_flag2", int'(viol_flags[2]), 1);

      // tRFC window
      do_reset();
      cmd(C_REF, 0, 0); nops(9); cmd(C_ACT, 3, 0);
      #2;
      chk("t4_code", int'(viol_code), 4);
      chk("t4_bank", int'(viol_bank), 0);
      nops(41); cmd(C_ACT, 2, 0);
      #2;
      chk("t4_late_valid", int'(viol_valid), 0);

      // State violations: ACT open bank, RD closed bank, REF with open bank
      do_reset();
      cmd(C_ACT, 4, 0); nops(19); cmd(C_ACT, 4, 0);
      #2;
      chk("t5_code5", int'(viol_code), 5);
      chk("t5_bank5", int'(viol_bank), 4);
      cmd(C_RD, 6, 0);
      #2;
      chk("t5_code6", int'(viol_code), 6);
      chk("t5_bank6", int'(viol_bank), 6);
      cmd(C_REF, 2, 0);
      #2;
      chk("t5_code7", int'(viol_code), 7);
      chk("t5_flags", int'(viol_flags), 7'b1110000);

      // Saturation, clear, clear+violation, monitor disabled
      do_reset();
      for (int i = 0; i < 20; i++) cmd(C_WR, 6, 0);
      #2;
      chk("t6_sat", int'(err_count), CMAX);
      step(C_NOP, 0, 0, 1, 0, 1, 1);
      #2;
      chk("t6_clr_flags", int'(viol_flags), 0);
      chk("t6_clr_cnt",   int'(err_count), 0);
      step(C_RD, 6, 0, 1, 0, 1, 1);
      #2;
      chk("t6_clrv_flags", int'(viol_flags), 7'b0100000);
      chk("t6_clrv_cnt",   int'(err_count), 1);
      step(C_RD, 6, 0, 1, 0, 0, 0);
      #2;
      chk("t6_dis_valid", int'(viol_valid), 0);
      chk("t6_dis_cnt",   int'(err_count), 1);

      // Asynchronous reset in the middle of open windows
      cmd(C_ACT, 1, 0); cmd(C_REF, 0, 0);
      #3 rst_n = 1'b0;
      #1 chk_zero("async");
      @(negedge clk);
      idle_inputs();
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      cmd(C_ACT, 1, 0);
      #2;
      chk("async_after_valid", int'(viol_valid), 0);

      // Randomized traffic over a few banks
      for (int i = 0; i < 4000; i++) begin
         r = $urandom_range(0, 99);
         if (r < 45)      rcw = C_NOP;
         else if (r < 60) rcw = C_ACT;
         else if (r < 66) rcw = C_RD;
         else if (r < 72) rcw = C_WR;
         else if (r < 84) rcw = C_PRE;
         else if (r < 87) rcw = C_REF;
         else             rcw = 3'($urandom);
         step(rcw, $urandom_range(0, 3), $urandom_range(0, 3) == 0,
              $urandom_range(0, 19) != 0, $urandom_range(0, 19) == 0,
              $urandom_range(0, 9) != 0, $urandom_range(0, 49) == 0);
         if ($urandom_range(0, 999) == 0) do_reset();
      end

      @(negedge clk);
      chk("queue_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
